// File: rtl/instr_pkg.sv
// Shared types for the NMCU instruction/response link and its adapter state.
package instr_pkg;

   // Instruction word travelling from the CPU to the NMCU decoder.
   typedef struct packed {
      logic [7:0]  opcode;
      logic [23:0] operand;
   } instruction_t;

   // Response word returned from an NMCU producer to the CPU.
   typedef struct packed {
      logic [7:0]  tag;
      logic [31:0] data;
   } nmcu_cpu_resp_t;

   // Link adapter state; encodings are visible on the link_state port.
   typedef enum logic [1:0] {
      LINK_DOWN  = 2'd0,
      LINK_UP    = 2'd1,
      LINK_DRAIN = 2'd2
   } link_state_e;

endpackage

// File: rtl/nmcu_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is presented as soon as it has
// been written, and pop simply advances past it. No bypass when empty.
module nmcu_sync_fifo #(
   parameter type T     = logic [7:0],
   parameter int  DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output T     head_data,
   output logic head_valid,
   output logic full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   T                 mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO or a pop from an empty one is silently ignored.
   assign do_push    = push & ~full;
   assign do_pop     = pop & head_valid;
   assign full       = (count_reg == CNT_W'(DEPTH));
   assign head_valid = (count_reg != '0);
   assign head_data  = mem[rd_ptr_reg];

   // Storage write; contents need no reset because occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); occupancy tracks fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/nmcu_link_adapter.sv
// Link adapter between the CPU instruction/response channels and the NMCU core:
// buffered instruction ingress, round-robin response egress, an in-flight
// instruction limit and a DOWN/UP/DRAIN link state machine.
module nmcu_link_adapter
   import instr_pkg::*;
#(
   parameter int INSTR_DEPTH     = 4,
   parameter int RESP_DEPTH      = 4,
   parameter int NUM_SRC         = 2,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   link_en,
   input  logic                                   cpu_instr_valid,
   output logic                                   cpu_instr_ready,
   input  instruction_t                           cpu_instruction,
   output logic                                   core_instr_valid,
   input  logic                                   core_instr_ready,
   output instruction_t                           core_instruction,
   input  logic [NUM_SRC-1:0]                     src_resp_valid,
   output logic [NUM_SRC-1:0]                     src_resp_ready,
   input  nmcu_cpu_resp_t [NUM_SRC-1:0]           src_response,
   output logic                                   nmcu_resp_valid,
   input  logic                                   nmcu_resp_ready,
   output nmcu_cpu_resp_t                         nmcu_response,
   output link_state_e                            link_state,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
   output logic                                   err_spurious_resp
);

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   link_state_e      state_reg;
   logic [OUT_W-1:0] outstanding_reg;
   logic             err_reg;
   logic [SRC_W-1:0] rr_ptr_reg;

   logic             instr_full;
   logic             resp_full;
   logic             accept;
   logic             deliver;
   logic             grant_any;
   logic [SRC_W-1:0] grant_idx;

   // Ingress is gated only by link state, buffer space and the in-flight cap.
   assign cpu_instr_ready = (state_reg == LINK_UP) && !instr_full &&
                            (outstanding_reg < OUT_W'(MAX_OUTSTANDING));
   assign accept  = cpu_instr_valid & cpu_instr_ready;
   assign deliver = nmcu_resp_valid & nmcu_resp_ready;

   assign link_state        = state_reg;
   assign outstanding       = outstanding_reg;
   assign err_spurious_resp = err_reg;

   nmcu_sync_fifo #(.T(instruction_t), .DEPTH(INSTR_DEPTH)) u_instr_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (accept),
      .push_data  (cpu_instruction),
      .pop        (core_instr_ready),
      .head_data  (core_instruction),
      .head_valid (core_instr_valid),
      .full       (instr_full)
   );

   nmcu_sync_fifo #(.T(nmcu_cpu_resp_t), .DEPTH(RESP_DEPTH)) u_resp_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (grant_any),
      .push_data  (src_response[grant_idx]),
      .pop        (nmcu_resp_ready),
      .head_data  (nmcu_response),
      .head_valid (nmcu_resp_valid),
      .full       (resp_full)
   );

   // Round-robin search starting at rr_ptr; no grant while the response FIFO is full.
   always_comb begin
      logic [SRC_W-1:0] cand;
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         cand = SRC_W'((int'(rr_ptr_reg) + i) % NUM_SRC);
         if (!grant_any && !resp_full && src_resp_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // One-hot ready back to the granted producer.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src_ready
      assign src_resp_ready[gi] = grant_any && (grant_idx == SRC_W'(gi));
   end

   // Priority pointer moves just past the most recent winner.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_reg <= '0;
      end else if (grant_any) begin
         rr_ptr_reg <= (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
      end
   end

   // In-flight count; a response with nothing in flight is flagged, count held at 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding_reg <= '0;
         err_reg         <= 1'b0;
      end else begin
         if (deliver && (outstanding_reg == '0)) begin
            err_reg <= 1'b1;
         end
         if (accept && !deliver) begin
            outstanding_reg <= outstanding_reg + OUT_W'(1);
         end else if (deliver && !accept && (outstanding_reg != '0)) begin
            outstanding_reg <= outstanding_reg - OUT_W'(1);
         end
      end
   end

   // Link FSM: DRAIN ignores link_en and waits for everything in flight to finish.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= LINK_DOWN;
      end else begin
         case (state_reg)
            LINK_DOWN: if (link_en) state_reg <= LINK_UP;
            LINK_UP:   if (!link_en) state_reg <= LINK_DRAIN;
            LINK_DRAIN: begin
               if ((outstanding_reg == '0) && !core_instr_valid && !nmcu_resp_valid) begin
                  state_reg <= LINK_DOWN;
               end
            end
            default:   state_reg <= LINK_DOWN;
         endcase
      end
   end

endmodule

// File: tb/tb_nmcu_link_adapter.sv
// Self-checking bench for nmcu_link_adapter: directed scenarios plus a random
// phase checked every cycle against a queue-based reference model.
module tb_nmcu_link_adapter;
   import instr_pkg::*;

   localparam int INSTR_DEPTH = 4;
   localparam int RESP_DEPTH  = 4;
   localparam int NUM_SRC     = 2;
   localparam int MAX_OUT     = 8;
   localparam int OUT_W       = $clog2(MAX_OUT + 1);

   logic                         clk = 1'b0;
   logic                         rst;
   logic                         link_en;
   logic                         cpu_instr_valid;
   logic                         cpu_instr_ready;
   instruction_t                 cpu_instruction;
   logic                         core_instr_valid;
   logic                         core_instr_ready;
   instruction_t                 core_instruction;
   logic [NUM_SRC-1:0]           src_resp_valid;
   logic [NUM_SRC-1:0]           src_resp_ready;
   nmcu_cpu_resp_t [NUM_SRC-1:0] src_response;
   logic                         nmcu_resp_valid;
   logic                         nmcu_resp_ready;
   nmcu_cpu_resp_t               nmcu_response;
   link_state_e                  link_state;
   logic [OUT_W-1:0]             outstanding;
   logic                         err_spurious_resp;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   instruction_t   m_iq[$];
   nmcu_cpu_resp_t m_rq[$];
   int             m_out   = 0;
   int             m_state = 0;
   int             m_rr    = 0;
   bit             m_err   = 1'b0;

   nmcu_link_adapter #(
      .INSTR_DEPTH(INSTR_DEPTH), .RESP_DEPTH(RESP_DEPTH),
      .NUM_SRC(NUM_SRC), .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clk(clk), .rst(rst), .link_en(link_en),
      .cpu_instr_valid(cpu_instr_valid), .cpu_instr_ready(cpu_instr_ready),
      .cpu_instruction(cpu_instruction),
      .core_instr_valid(core_instr_valid), .core_instr_ready(core_instr_ready),
      .core_instruction(core_instruction),
      .src_resp_valid(src_resp_valid), .src_resp_ready(src_resp_ready),
      .src_response(src_response),
      .nmcu_resp_valid(nmcu_resp_valid), .nmcu_resp_ready(nmcu_resp_ready),
      .nmcu_response(nmcu_response),
      .link_state(link_state), .outstanding(outstanding),
      .err_spurious_resp(err_spurious_resp)
   );

   always #5 clk = ~clk;

   function automatic bit m_cpu_ready();
      return (m_state == 1) && (m_iq.size() < INSTR_DEPTH) && (m_out < MAX_OUT);
   endfunction

   function automatic int m_grant();
      if (m_rq.size() >= RESP_DEPTH) return -1;
      for (int i = 0; i < NUM_SRC; i++) begin
         int c;
         c = (m_rr + i) % NUM_SRC;
         if (src_resp_valid[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [NUM_SRC-1:0] m_grant_vec();
      logic [NUM_SRC-1:0] v;
      int g;
      v = '0;
      g = m_grant();
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   // Advance the model by one clock edge using the inputs currently applied.
   function automatic void model_update();
      bit accept, pop_i, deliver;
      int g;
      if (rst) begin
         m_iq.delete(); m_rq.delete();
         m_out = 0; m_state = 0; m_rr = 0; m_err = 1'b0;
         return;
      end
      accept  = cpu_instr_valid && m_cpu_ready();
      pop_i   = (m_iq.size() > 0) && core_instr_ready;
      deliver = (m_rq.size() > 0) && nmcu_resp_ready;
      g       = m_grant();
      case (m_state)
         0:       if (link_en) m_state = 1;
         1:       if (!link_en) m_state = 2;
         default: if (m_out == 0 && m_iq.size() == 0 && m_rq.size() == 0) m_state = 0;
      endcase
      if (deliver && m_out == 0) m_err = 1'b1;
      if (accept && !deliver) m_out++;
      else if (deliver && !accept && m_out > 0) m_out--;
      if (pop_i) void'(m_iq.pop_front());
      if (accept) m_iq.push_back(cpu_instruction);
      if (deliver) void'(m_rq.pop_front());
      if (g >= 0) begin
         m_rq.push_back(src_response[g]);
         m_rr = (g + 1) % NUM_SRC;
      end
   endfunction

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      cpu_instr_valid  = 1'b0;
      cpu_instruction  = '0;
      core_instr_ready = 1'b0;
      src_resp_valid   = '0;
      src_response     = '0;
      nmcu_resp_ready  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      link_en = 1'b0;
      idle_inputs();
      step();
      step();
      rst = 1'b0;
   endtask

   function automatic instruction_t rand_instr();
      return '{opcode: 8'($urandom), operand: 24'($urandom)};
   endfunction

   function automatic nmcu_cpu_resp_t rand_resp();
      return '{tag: 8'($urandom), data: $urandom};
   endfunction

   // Feed n responses from source 0 and let them reach the CPU.
   task automatic return_responses(input int n);
      cpu_instr_valid = 1'b0;
      nmcu_resp_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         src_resp_valid = NUM_SRC'(1);
         src_response[0] = rand_resp();
         step();
      end
      src_resp_valid = '0;
      for (int k = 0; k < RESP_DEPTH + 2; k++) step();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_cmp++; if (link_state !== LINK_DOWN) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", link_state, LINK_DOWN); end
      n_cmp++; if (cpu_instr_ready !== 1'b0) begin n_err++; $display("FAIL reset_cpu_ready: got %b expected 0", cpu_instr_ready); end
      n_cmp++; if (core_instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_core_valid: got %b expected 0", core_instr_valid); end
      n_cmp++; if (nmcu_resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b expected 0", nmcu_resp_valid); end
      n_cmp++; if (outstanding !== '0) begin n_err++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
      n_cmp++; if (err_spurious_resp !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err_spurious_resp); end
      n_cmp++; if (src_resp_ready !== '0) begin n_err++; $display("FAIL reset_src_ready: got %b expected 0", src_resp_ready); end
   endtask

   task automatic test_link_up();
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (cpu_instr_ready !== 1'b0) begin n_err++; $display("FAIL linkdown_ready cycle %0d: got %b expected 0", k, cpu_instr_ready); end
         step();
      end
      link_en = 1'b1;
      #1;
      n_cmp++; if (link_state !== LINK_DOWN) begin n_err++; $display("FAIL linkup_early: got %0d expected %0d", link_state, LINK_DOWN); end
      step();
      n_cmp++; if (link_state !== LINK_UP) begin n_err++; $display("FAIL linkup_state: got %0d expected %0d", link_state, LINK_UP); end
      n_cmp++; if (cpu_instr_ready !== 1'b1) begin n_err++; $display("FAIL linkup_ready: got %b expected 1", cpu_instr_ready); end
   endtask

   task automatic test_backpressure();
      instruction_t sent[$];
      core_instr_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cpu_instr_valid = 1'b1;
         cpu_instruction = rand_instr();
         #1;
         n_cmp++; if (cpu_instr_ready !== (k < INSTR_DEPTH)) begin n_err++; $display("FAIL bp_ready push %0d: got %b expected %b", k, cpu_instr_ready, k < INSTR_DEPTH); end
         if (cpu_instr_ready) sent.push_back(cpu_instruction);
         step();
      end
      cpu_instr_valid = 1'b0;
      core_instr_ready = 1'b1;
      for (int k = 0; k < INSTR_DEPTH; k++) begin
         #1;
         n_cmp++;
         if (core_instr_valid !== 1'b1 || k >= sent.size() || core_instruction !== sent[k]) begin
            n_err++; $display("FAIL bp_order %0d: got valid=%b data=%h expected valid=1 data=%h", k, core_instr_valid, core_instruction, (k < sent.size()) ? sent[k] : '0);
         end
         step();
      end
      n_cmp++; if (core_instr_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b expected 0", core_instr_valid); end
      n_cmp++; if (outstanding !== OUT_W'(INSTR_DEPTH)) begin n_err++; $display("FAIL bp_outstanding: got %0d expected %0d", outstanding, INSTR_DEPTH); end
      return_responses(INSTR_DEPTH);
      n_cmp++; if (outstanding !== '0) begin n_err++; $display("FAIL bp_cleanup: got %0d expected 0", outstanding); end
   endtask

   task automatic test_outstanding_limit();
      int accepted = 0;
      core_instr_ready = 1'b1;
      for (int k = 0; k < MAX_OUT + 3; k++) begin
         cpu_instr_valid = 1'b1;
         cpu_instruction = rand_instr();
         #1;
         n_cmp++; if (cpu_instr_ready !== (k < MAX_OUT)) begin n_err++; $display("FAIL lim_ready cycle %0d: got %b expected %b", k, cpu_instr_ready, k < MAX_OUT); end
         if (cpu_instr_ready) accepted++;
         step();
      end
      cpu_instr_valid = 1'b0;
      n_cmp++; if (accepted != MAX_OUT || outstanding !== OUT_W'(MAX_OUT)) begin n_err++; $display("FAIL lim_count: got accepted=%0d outstanding=%0d expected %0d", accepted, outstanding, MAX_OUT); end
      nmcu_resp_ready = 1'b1;
      src_resp_valid = NUM_SRC'(1);
      src_response[0] = rand_resp();
      step();
      src_resp_valid = '0;
      #1;
      n_cmp++; if (nmcu_resp_valid !== 1'b1 || cpu_instr_ready !== 1'b0) begin n_err++; $display("FAIL lim_resp_head: got valid=%b ready=%b expected valid=1 ready=0", nmcu_resp_valid, cpu_instr_ready); end
      step();
      n_cmp++; if (cpu_instr_ready !== 1'b1 || outstanding !== OUT_W'(MAX_OUT - 1)) begin n_err++; $display("FAIL lim_release: got ready=%b outstanding=%0d expected ready=1 outstanding=%0d", cpu_instr_ready, outstanding, MAX_OUT - 1); end
      return_responses(MAX_OUT - 1);
   endtask

   task automatic test_round_robin();
      nmcu_cpu_resp_t exp_q[$];
      do_reset();
      nmcu_resp_ready = 1'b1;
      src_resp_valid = '1;
      for (int k = 0; k < 8; k++) begin
         for (int s = 0; s < NUM_SRC; s++) src_response[s] = rand_resp();
         #1;
         n_cmp++; if (src_resp_ready !== (NUM_SRC'(1) << (k % NUM_SRC))) begin n_err++; $display("FAIL rr_grant cycle %0d: got %b expected %b", k, src_resp_ready, NUM_SRC'(1) << (k % NUM_SRC)); end
         if (k > 0) begin
            n_cmp++;
            if (nmcu_resp_valid !== 1'b1 || nmcu_response !== exp_q[0]) begin n_err++; $display("FAIL rr_order cycle %0d: got valid=%b data=%h expected %h", k, nmcu_resp_valid, nmcu_response, exp_q[0]); end
            void'(exp_q.pop_front());
         end
         exp_q.push_back(src_response[k % NUM_SRC]);
         step();
      end
      src_resp_valid = '0;
      step();
      do_reset();
   endtask

   task automatic test_drain();
      int cyc = 0;
      link_en = 1'b1;
      step();
      core_instr_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cpu_instr_valid = 1'b1;
         cpu_instruction = rand_instr();
         step();
      end
      cpu_instr_valid = 1'b0;
      link_en = 1'b0;
      step();
      n_cmp++; if (link_state !== LINK_DRAIN || cpu_instr_ready !== 1'b0 || outstanding !== OUT_W'(3)) begin n_err++; $display("FAIL drain_enter: got state=%0d ready=%b out=%0d expected state=2 ready=0 out=3", link_state, cpu_instr_ready, outstanding); end
      link_en = 1'b1;
      nmcu_resp_ready = 1'b1;
      while (m_state != 0 && cyc < 30) begin
         src_resp_valid = (cyc < 3) ? NUM_SRC'(1) : '0;
         src_response[0] = rand_resp();
         #1;
         n_cmp++; if (link_state !== link_state_e'(m_state) || outstanding !== OUT_W'(m_out)) begin n_err++; $display("FAIL drain_track cycle %0d: got state=%0d out=%0d expected state=%0d out=%0d", cyc, link_state, outstanding, m_state, m_out); end
         step();
         cyc++;
      end
      src_resp_valid = '0;
      n_cmp++; if (cyc >= 30 || link_state !== LINK_DOWN || err_spurious_resp !== 1'b0) begin n_err++; $display("FAIL drain_exit: got state=%0d err=%b after %0d cycles expected state=0 err=0", link_state, err_spurious_resp, cyc); end
      link_en = 1'b0;
   endtask

   task automatic test_spurious();
      do_reset();
      nmcu_resp_ready = 1'b1;
      src_resp_valid = NUM_SRC'(2);
      src_response[1] = rand_resp();
      step();
      src_resp_valid = '0;
      #1;
      n_cmp++; if (nmcu_resp_valid !== 1'b1 || err_spurious_resp !== 1'b0) begin n_err++; $display("FAIL spur_head: got valid=%b err=%b expected valid=1 err=0", nmcu_resp_valid, err_spurious_resp); end
      step();
      n_cmp++; if (err_spurious_resp !== 1'b1 || outstanding !== '0) begin n_err++; $display("FAIL spur_flag: got err=%b out=%0d expected err=1 out=0", err_spurious_resp, outstanding); end
      for (int k = 0; k < 3; k++) step();
      n_cmp++; if (err_spurious_resp !== 1'b1) begin n_err++; $display("FAIL spur_sticky: got %b expected 1", err_spurious_resp); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      link_en = 1'b1;
      step();
      for (int k = 0; k < 2; k++) begin
         cpu_instr_valid = 1'b1;
         cpu_instruction = rand_instr();
         src_resp_valid = NUM_SRC'(1);
         src_response[0] = rand_resp();
         step();
      end
      idle_inputs();
      #1;
      n_cmp++; if (core_instr_valid !== 1'b1 || nmcu_resp_valid !== 1'b1 || outstanding !== OUT_W'(2)) begin n_err++; $display("FAIL rstmid_pre: got cv=%b rv=%b out=%0d expected 1 1 2", core_instr_valid, nmcu_resp_valid, outstanding); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++; if (core_instr_valid !== 1'b0 || nmcu_resp_valid !== 1'b0 || outstanding !== '0 || link_state !== LINK_DOWN || cpu_instr_ready !== 1'b0) begin
         n_err++; $display("FAIL rstmid_post: got cv=%b rv=%b out=%0d state=%0d ready=%b expected all 0", core_instr_valid, nmcu_resp_valid, outstanding, link_state, cpu_instr_ready);
      end
      link_en = 1'b0;
      step();
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 24) == 0) link_en = ~link_en;
         cpu_instr_valid  = 1'($urandom);
         cpu_instruction  = rand_instr();
         core_instr_ready = ($urandom_range(0, 3) != 0);
         src_resp_valid   = NUM_SRC'($urandom);
         for (int s = 0; s < NUM_SRC; s++) src_response[s] = rand_resp();
         nmcu_resp_ready  = ($urandom_range(0, 3) != 0);
         #1;
         n_cmp++;
         if (cpu_instr_ready !== m_cpu_ready() ||
             core_instr_valid !== (m_iq.size() > 0) ||
             (m_iq.size() > 0 && core_instruction !== m_iq[0]) ||
             src_resp_ready !== m_grant_vec() ||
             nmcu_resp_valid !== (m_rq.size() > 0) ||
             (m_rq.size() > 0 && nmcu_response !== m_rq[0]) ||
             link_state !== link_state_e'(m_state) ||
             outstanding !== OUT_W'(m_out) ||
             err_spurious_resp !== m_err) begin
            n_err++;
            bad++;
            if (bad <= 5) $display("FAIL random cycle %0d: got rdy=%b cv=%b srdy=%b rv=%b st=%0d out=%0d err=%b expected rdy=%b cv=%b srdy=%b rv=%b st=%0d out=%0d err=%b",
               k, cpu_instr_ready, core_instr_valid, src_resp_ready, nmcu_resp_valid, link_state, outstanding, err_spurious_resp,
               m_cpu_ready(), m_iq.size() > 0, m_grant_vec(), m_rq.size() > 0, m_state, m_out, m_err);
         end
         step();
      end
   endtask

   initial begin
      rst = 1'b1;
      link_en = 1'b0;
      idle_inputs();
      test_reset();
      test_link_up();
      test_backpressure();
      test_outstanding_limit();
      test_round_robin();
      test_drain();
      test_spurious();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
